// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bundle: ID-stage instruction description going in,
// stall decision and statistics coming back out.
interface hazard_scoreboard_if #(
    parameter int NREG  = 8,
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
);
    localparam int REG_W = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int INF_W = $clog2(DEPTH + 1);

    logic             id_valid;
    logic             src1_vld;
    logic             src2_vld;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             early;
    logic             dst_vld;
    logic [REG_W-1:0] dst;
    logic             is_load;
    logic             mem_stall;
    logic             flush;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;
    logic [INF_W-1:0] inflight;

    // Pipeline control side: describes the ID instruction, receives the stall.
    modport master (
        output id_valid, src1_vld, src2_vld, src1, src2, early,
               dst_vld, dst, is_load, mem_stall, flush,
        input  stall, stall_cnt, inflight
    );

    // Scoreboard side.
    modport slave (
        input  id_valid, src1_vld, src2_vld, src1, src2, early,
               dst_vld, dst, is_load, mem_stall, flush,
        output stall, stall_cnt, inflight
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Data-hazard scoreboard for an in-order pipeline. Tracks the destination
// register of every instruction past ID and raises a combinational stall
// when the ID instruction reads a value that cannot be forwarded in time.
module hazard_scoreboard #(
    parameter int NREG   = 8,
    parameter int DEPTH  = 3,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave sb
);
    localparam int REG_W = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int INF_W = $clog2(DEPTH + 1);

    // Slot 0 is the youngest (ID/EX); slot DEPTH-1 is the oldest tracked stage.
    logic [DEPTH-1:0] r_v;
    logic [DEPTH-1:0] r_ld;
    logic [REG_W-1:0] r_dst [DEPTH];
    logic [CNT_W-1:0] r_stall_cnt;
    logic [INF_W-1:0] r_inflight;

    logic [DEPTH-1:0] w_v_next;
    logic [DEPTH-1:0] w_ld_next;
    logic [REG_W-1:0] w_dst_next [DEPTH];
    logic [INF_W-1:0] w_inflight_next;
    logic [DEPTH-1:0] w_match;
    logic             w_hz;
    logic             w_stall;

    // Per-slot source/destination comparison; one hit per slot no matter how
    // many sources match, so duplicates never add extra stall cycles.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign w_match[gi] = r_v[gi] &&
                                 ((sb.src1_vld && (sb.src1 == r_dst[gi])) ||
                                  (sb.src2_vld && (sb.src2 == r_dst[gi])));
        end
    endgenerate

    // Hazard rule: with forwarding only loads (and, for ID-resolved
    // instructions, anything still in EX) block; without forwarding every
    // tracked producer blocks until it has written the register file.
    always_comb begin
        w_hz = 1'b0;
        if (FWD_EN != 0) begin
            if (sb.early) begin
                w_hz = w_match[0] | (w_match[1] & r_ld[1]);
            end else begin
                w_hz = w_match[0] & r_ld[0];
            end
        end else begin
            w_hz = |w_match;
        end
    end

    // A frozen or squashed ID instruction never requests a bubble.
    assign w_stall = sb.id_valid && !sb.flush && !sb.mem_stall && w_hz;

    // Next slot contents: hold on memory stall, otherwise shift and insert
    // either a bubble (hazard) or the ID instruction's destination.
    always_comb begin
        w_v_next   = r_v;
        w_ld_next  = r_ld;
        w_dst_next = r_dst;
        if (!sb.mem_stall) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                w_v_next[k]   = r_v[k-1];
                w_ld_next[k]  = r_ld[k-1];
                w_dst_next[k] = r_dst[k-1];
            end
            if (w_stall) begin
                w_v_next[0] = 1'b0;
            end else begin
                w_v_next[0]   = sb.id_valid && sb.dst_vld && !sb.flush;
                w_ld_next[0]  = sb.is_load;
                w_dst_next[0] = sb.dst;
            end
        end
    end

    // Population count of the next slot state, so the registered count
    // always agrees with the slots it describes.
    always_comb begin
        w_inflight_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_inflight_next = w_inflight_next + INF_W'(w_v_next[k]);
        end
    end

    // Slot, counter and occupancy registers; reset wipes every pending hazard.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v         <= '0;
            r_ld        <= '0;
            r_dst       <= '{default: '0};
            r_stall_cnt <= '0;
            r_inflight  <= '0;
        end else begin
            r_v        <= w_v_next;
            r_ld       <= w_ld_next;
            r_dst      <= w_dst_next;
            r_inflight <= w_inflight_next;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign sb.stall     = w_stall;
    assign sb.stall_cnt = r_stall_cnt;
    assign sb.inflight  = r_inflight;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three configurations (forwarding, interlock,
// deep interlock with narrow counter) driven by the same stimulus and checked
// every cycle against an age-list model of in-flight producers.
module tb_hazard_scoreboard;
    logic clk;
    logic rst;

    hazard_scoreboard_if #(.NREG(8), .DEPTH(3), .CNT_W(16)) if_fwd ();
    hazard_scoreboard_if #(.NREG(8), .DEPTH(3), .CNT_W(16)) if_ilk ();
    hazard_scoreboard_if #(.NREG(8), .DEPTH(5), .CNT_W(4))  if_sat ();

    hazard_scoreboard #(.NREG(8), .DEPTH(3), .FWD_EN(1), .CNT_W(16)) u_fwd (.clk(clk), .rst(rst), .sb(if_fwd));
    hazard_scoreboard #(.NREG(8), .DEPTH(3), .FWD_EN(0), .CNT_W(16)) u_ilk (.clk(clk), .rst(rst), .sb(if_ilk));
    hazard_scoreboard #(.NREG(8), .DEPTH(5), .FWD_EN(0), .CNT_W(4))  u_sat (.clk(clk), .rst(rst), .sb(if_sat));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus
    bit id_v, s1v, s2v, erl, dv, ldf, ms, fl;
    int s1, s2, dd;

    always_comb begin
        if_fwd.id_valid = id_v; if_fwd.src1_vld = s1v; if_fwd.src2_vld = s2v;
        if_fwd.src1 = 3'(s1); if_fwd.src2 = 3'(s2); if_fwd.early = erl;
        if_fwd.dst_vld = dv; if_fwd.dst = 3'(dd); if_fwd.is_load = ldf;
        if_fwd.mem_stall = ms; if_fwd.flush = fl;
        if_ilk.id_valid = id_v; if_ilk.src1_vld = s1v; if_ilk.src2_vld = s2v;
        if_ilk.src1 = 3'(s1); if_ilk.src2 = 3'(s2); if_ilk.early = erl;
        if_ilk.dst_vld = dv; if_ilk.dst = 3'(dd); if_ilk.is_load = ldf;
        if_ilk.mem_stall = ms; if_ilk.flush = fl;
        if_sat.id_valid = id_v; if_sat.src1_vld = s1v; if_sat.src2_vld = s2v;
        if_sat.src1 = 3'(s1); if_sat.src2 = 3'(s2); if_sat.early = erl;
        if_sat.dst_vld = dv; if_sat.dst = 3'(dd); if_sat.is_load = ldf;
        if_sat.mem_stall = ms; if_sat.flush = fl;
    end

    // Reference model: per configuration, an age-ordered list of producers
    // (index 0 = most recently issued) plus a saturating stall tally.
    typedef struct {
        bit v;
        int dst;
        bit ld;
    } ent_t;

    ent_t mp [3][8];
    int   m_cnt [3];
    int   DEP  [3] = '{3, 3, 5};
    int   FWD  [3] = '{1, 0, 0};
    int   CMAX [3] = '{65535, 65535, 15};

    int obs_stall [3];
    int obs_cnt   [3];
    int obs_inf   [3];

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  armed = 0;
    int  n_step = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d (step %0d)", tag, got, exp, n_step);
        end
    endtask

    function automatic bit m_hz(int i);
        bit h = 0;
        for (int k = 0; k < DEP[i]; k++) begin
            bit m;
            m = mp[i][k].v && ((s1v && s1 == mp[i][k].dst) || (s2v && s2 == mp[i][k].dst));
            if (FWD[i] != 0) begin
                if (erl) begin
                    if (k == 0 && m) h = 1;
                    if (k == 1 && m && mp[i][k].ld) h = 1;
                end else if (k == 0 && m && mp[i][k].ld) begin
                    h = 1;
                end
            end else if (m) begin
                h = 1;
            end
        end
        return h;
    endfunction

    function automatic int m_inf(int i);
        int c = 0;
        for (int k = 0; k < DEP[i]; k++) c += int'(mp[i][k].v);
        return c;
    endfunction

    // One clock cycle: sample at the falling edge, compare, advance model.
    task automatic step();
        bit st;
        @(negedge clk);
        obs_stall = '{int'(if_fwd.stall), int'(if_ilk.stall), int'(if_sat.stall)};
        obs_cnt   = '{int'(if_fwd.stall_cnt), int'(if_ilk.stall_cnt), int'(if_sat.stall_cnt)};
        obs_inf   = '{int'(if_fwd.inflight), int'(if_ilk.inflight), int'(if_sat.inflight)};
        for (int i = 0; i < 3; i++) begin
            st = id_v && !fl && !ms && m_hz(i);
            if (armed) begin
                check_val($sformatf("stall[%0d]", i), obs_stall[i], int'(st));
                check_val($sformatf("stall_cnt[%0d]", i), obs_cnt[i], m_cnt[i]);
                check_val($sformatf("inflight[%0d]", i), obs_inf[i], m_inf(i));
            end
            if (rst) begin
                for (int k = 0; k < 8; k++) mp[i][k].v = 0;
                m_cnt[i] = 0;
            end else if (!ms) begin
                for (int k = DEP[i] - 1; k >= 1; k--) mp[i][k] = mp[i][k-1];
                mp[i][0].v   = st ? 1'b0 : (id_v && dv && !fl);
                mp[i][0].dst = dd;
                mp[i][0].ld  = ldf;
                if (st && m_cnt[i] < CMAX[i]) m_cnt[i]++;
            end
        end
        $display("step %0d rst=%0b id=%0b ms=%0b fl=%0b stall=%0d%0d%0d cnt=%0d/%0d/%0d inf=%0d/%0d/%0d",
                 n_step, rst, id_v, ms, fl, obs_stall[0], obs_stall[1], obs_stall[2],
                 obs_cnt[0], obs_cnt[1], obs_cnt[2], obs_inf[0], obs_inf[1], obs_inf[2]);
        if (rst) armed = 1;
        n_step++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input bit v, input bit a1v, input int a1, input bit a2v, input int a2,
                          input bit e, input bit w, input int d, input bit l);
        id_v = v; s1v = a1v; s1 = a1; s2v = a2v; s2 = a2;
        erl = e; dv = w; dd = d; ldf = l; ms = 0; fl = 0;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1; nop(); step(); rst = 0;
    endtask

    initial begin
        rst = 1;
        nop();
        step();
        step();
        rst = 0;
        check_val("reset_cnt", obs_cnt[0], 0);
        check_val("reset_inf", obs_inf[1], 0);

        // LD R3 ; ADD R4,R3,R1 (forwarding)
        set_id(1, 0, 0, 0, 0, 0, 1, 3, 1); step();
        set_id(1, 1, 3, 1, 1, 0, 1, 4, 0); step();
        check_val("ldu_stall", obs_stall[0], 1);
        check_val("ldu_cnt0", obs_cnt[0], 0);
        step();
        check_val("ldu_release", obs_stall[0], 0);
        check_val("ldu_cnt1", obs_cnt[0], 1);
        nop(); step();
        check_val("ldu_inf", obs_inf[0], 2);

        // ADD R2 ; BEQZ R2
        do_reset();
        set_id(1, 1, 0, 1, 1, 0, 1, 2, 0); step();
        set_id(1, 1, 2, 0, 0, 1, 0, 0, 0); step();
        check_val("br_alu", obs_stall[0], 1);
        step();
        check_val("br_alu_rel", obs_stall[0], 0);
        // LD R2 ; NOP ; BEQZ R2
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 1, 2, 1); step();
        nop(); step();
        set_id(1, 1, 2, 0, 0, 1, 0, 0, 0); step();
        check_val("br_ld_gap", obs_stall[0], 1);
        step();
        check_val("br_ld_rel", obs_stall[0], 0);
        // ADD R2 ; NOP ; BEQZ R2
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 1, 2, 0); step();
        nop(); step();
        set_id(1, 1, 2, 0, 0, 1, 0, 0, 0); step();
        check_val("br_alu_gap", obs_stall[0], 0);

        // Interlock: ADD R5 ; SUB R6,R5,R5
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 1, 5, 0); step();
        set_id(1, 1, 5, 1, 5, 0, 1, 6, 0);
        for (int j = 0; j < 3; j++) begin
            step();
            check_val("ilk_stall", obs_stall[1], 1);
            check_val("ilk_inf", obs_inf[1], 1);
        end
        step();
        check_val("ilk_issue", obs_stall[1], 0);
        check_val("ilk_cnt", obs_cnt[1], 3);
        nop(); step();
        check_val("ilk_inf_sub", obs_inf[1], 1);

        // Memory stall over a load-use pair
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 1, 3, 1); step();
        set_id(1, 1, 3, 0, 0, 0, 1, 4, 0);
        ms = 1;
        for (int j = 0; j < 4; j++) begin
            step();
            check_val("ms_stall", obs_stall[0], 0);
            check_val("ms_inf", obs_inf[0], 1);
        end
        ms = 0; step();
        check_val("ms_release", obs_stall[0], 1);

        // Flushed load-use consumer
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 1, 3, 1); step();
        set_id(1, 1, 3, 0, 0, 0, 1, 4, 0); fl = 1; step();
        check_val("flush_stall", obs_stall[0], 0);
        nop(); step();
        check_val("flush_inf", obs_inf[0], 1);

        // Reset in the middle of an interlock
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 1, 5, 0); step();
        set_id(1, 1, 5, 1, 5, 0, 1, 6, 0); step(); step();
        rst = 1; step(); rst = 0; step();
        check_val("rst_ilk_stall", obs_stall[1], 0);
        check_val("rst_ilk_cnt", obs_cnt[1], 0);

        // Saturation of the 4-bit counter: five interlocks of five cycles
        do_reset();
        for (int j = 0; j < 5; j++) begin
            set_id(1, 0, 0, 0, 0, 0, 1, 5, 0); step();
            set_id(1, 1, 5, 1, 5, 0, 1, 6, 0);
            for (int c = 0; c < 6; c++) step();
        end
        nop(); step();
        check_val("sat_cnt", obs_cnt[2], 15);

        // Randomised traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            id_v = ($urandom_range(0, 3) != 0);
            s1v  = ($urandom_range(0, 3) != 0);
            s2v  = ($urandom_range(0, 1) != 0);
            s1   = $urandom_range(0, 7);
            s2   = $urandom_range(0, 7);
            erl  = ($urandom_range(0, 3) == 0);
            dv   = ($urandom_range(0, 3) != 0);
            dd   = $urandom_range(0, 7);
            ldf  = ($urandom_range(0, 2) == 0);
            ms   = ($urandom_range(0, 7) == 0);
            fl   = ($urandom_range(0, 11) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 8, architectural register count; REG_W = clog2(NREG).
REQ-002 Parameter DEPTH, default 3, tracked in-flight stages after ID (slot 0 = ID/EX, slot 1 = EX/MEM, slot 2 = MEM/WB); legal range 2..6.
REQ-003 Parameter FWD_EN, default 1, selects forwarding mode (1) or no-forwarding interlock mode (0).
REQ-004 Parameter CNT_W, default 16, stall-counter width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 id_valid  input  1  ID holds a real instruction.
REQ-008 src1_vld / src2_vld  input  1 each  Rs / Rt read by the ID instruction.
REQ-009 src1 / src2  input  REG_W each  source register numbers.
REQ-010 early  input  1  ID instruction resolves in ID (branch, JR, JALR).
REQ-011 dst_vld  input  1  ID instruction writes a register.
REQ-012 dst  input  REG_W  destination register number.
REQ-013 is_load  input  1  ID instruction is a memory read.
REQ-014 mem_stall  input  1  memory busy; whole pipeline frozen.
REQ-015 flush  input  1  ID instruction is squashed this cycle.
REQ-016 stall  output  1  combinational; hold PC and IF/ID, insert bubble.
REQ-017 stall_cnt  output  CNT_W  registered, saturating count of hazard-stall cycles.
REQ-018 inflight  output  clog2(DEPTH+1)  registered; count of valid writing slots.

Function
REQ-019 Each slot k holds {v, dst, ld}; v set only for instructions with dst_vld.
REQ-020 match(k) = slot k v, and (src1_vld and src1 == dst(k), or src2_vld and src2 == dst(k)).
REQ-021 FWD_EN=1, non-early: hz = match(0) and ld(0) (load-use).
REQ-022 FWD_EN=1, early: hz = match(0), or match(1) and ld(1).
REQ-023 FWD_EN=0: hz = match(k) for any k in 0..DEPTH-1, regardless of early; register-file write-before-read covers the retiring stage.
REQ-024 stall = id_valid and not flush and not mem_stall and hz.
REQ-025 Update priority when rst=0: mem_stall, then stall, then normal.
REQ-026 mem_stall=1: all slots hold, stall_cnt holds.
REQ-027 stall=1: slots k>=1 take slot k-1; slot 0 takes a bubble (v=0); stall_cnt increments.
REQ-028 Normal (also flush=1): slots shift; slot 0 takes {id_valid and dst_vld and not flush, dst, is_load}.
REQ-029 Slot DEPTH-1 contents are discarded on shift.
REQ-030 stall_cnt saturates at 2^CNT_W-1 and never wraps.
REQ-031 inflight equals the popcount of v over all slots after each update; it has one-cycle latency from slot change.
REQ-032 One slot-0 entry per ID instruction; a stalled instruction is recorded once, on the cycle stall deasserts.
REQ-033 The same register matching two slots, or both sources, produces a single stall, not cumulative stalls.

Reset
REQ-034 rst=1 at a clock edge clears all slot v bits, stall_cnt=0 and inflight=0, overriding mem_stall and flush.
REQ-035 During rst, stall evaluates from cleared slots and is therefore 0 from the first post-reset cycle.
REQ-036 Reset asserted mid-stall drops all in-flight entries; no pending hazard survives reset.

Verification
REQ-037 FWD_EN=1: LD R3 then ADD R4,R3,R1 -> stall=1 for exactly 1 cycle, stall_cnt 0->1, ADD enters slot 0 on the next cycle.
REQ-038 FWD_EN=1: ADD R2 then BEQZ R2 -> stall 1 cycle; LD R2, NOP, BEQZ R2 -> stall 1 cycle; ADD R2, NOP, BEQZ R2 -> no stall.
REQ-039 FWD_EN=0, DEPTH=3: ADD R5 then SUB R6,R5,R5 -> stall 3 consecutive cycles, then issue; inflight reads 1,1,1 then 1 after SUB issues.
REQ-040 LD R3 in slot 0, consumer in ID, mem_stall held 4 cycles -> stall=0 and slots frozen during that time; after mem_stall drops -> stall=1 for one cycle.
REQ-041 Load-use hazard with flush=1 -> stall=0 and slot 0 receives a bubble; rst asserted during a 3-cycle interlock -> stall=0 the next cycle, stall_cnt=0.
REQ-042 CNT_W=4: 20 forced hazard cycles -> stall_cnt sticks at 15.
